// File: rtl/rf_pkg.sv
// Shared types and defaults for the rename register file.
// The operand and commit structs use the default widths. A top instantiated
// with non-default REG_NUM/DATA_W/TAG_W must also resize these typedefs.
package rf_pkg;

  localparam int REG_NUM_DEF = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int AW_DEF      = $clog2(REG_NUM_DEF);

  // A resolved source operand. The value is meaningful only when busy is 0.
  // The tag is meaningful only when busy is 1.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] value;
    logic [TAG_W_DEF-1:0]  tag;
    logic                  busy;
  } operand_t;

  // One retiring result coming back from the ROB.
  typedef struct packed {
    logic                  valid;
    logic [AW_DEF-1:0]     rd;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } commit_t;

  // Wakes a held operand when its pending tag is retired.
  // Only the tag is compared, because ROB tags are unique while in flight.
  function automatic operand_t wake_operand(operand_t op, commit_t cmt);
    operand_t res;
    res = op;
    if (cmt.valid && op.busy && (op.tag == cmt.tag)) begin
      res.busy  = 1'b0;
      res.value = cmt.data;
    end
    return res;
  endfunction

endpackage

// File: rtl/rename_reg_file_if.sv
// Decoder / ROB / reservation-station side bundle of the rename register file.
// The slave modport is the register file.
// The master modport is whoever drives it, i.e. the decoder and ROB, or a bench.
interface rename_reg_file_if
  import rf_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int AW      = $clog2(REG_NUM)
) ();

  logic              flush_i;

  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [AW-1:0]     issue_rs1_i;
  logic [AW-1:0]     issue_rs2_i;
  logic [AW-1:0]     issue_rd_i;
  logic [TAG_W-1:0]  issue_tag_i;

  logic              commit_valid_i;
  logic [AW-1:0]     commit_rd_i;
  logic [TAG_W-1:0]  commit_tag_i;
  logic [DATA_W-1:0] commit_data_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_v1_o;
  logic [DATA_W-1:0] out_v2_o;
  logic [TAG_W-1:0]  out_q1_o;
  logic [TAG_W-1:0]  out_q2_o;
  logic              out_busy1_o;
  logic              out_busy2_o;
  logic [TAG_W-1:0]  out_tag_o;

  modport slave (
    input  flush_i,
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_tag_i,
    output issue_ready_o,
    input  commit_valid_i, commit_rd_i, commit_tag_i, commit_data_i,
    output out_valid_o, out_v1_o, out_v2_o, out_q1_o, out_q2_o,
    output out_busy1_o, out_busy2_o, out_tag_o,
    input  out_ready_i
  );

  modport master (
    output flush_i,
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_tag_i,
    input  issue_ready_o,
    output commit_valid_i, commit_rd_i, commit_tag_i, commit_data_i,
    input  out_valid_o, out_v1_o, out_v2_o, out_q1_o, out_q2_o,
    input  out_busy1_o, out_busy2_o, out_tag_o,
    output out_ready_i
  );

endinterface

// File: rtl/rf_operand_resolve.sv
// Resolves one source register against the rename table.
// A retiring result for the current producer on this same cycle is
// forwarded, so the instruction does not wait on a tag that is already gone.
// x0 always reads as a ready zero.
module rf_operand_resolve
  import rf_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int AW      = $clog2(REG_NUM)
) (
  input  logic [AW-1:0]     rs,
  input  logic [DATA_W-1:0] value_tbl [REG_NUM],
  input  logic [REG_NUM-1:0] busy_tbl,
  input  logic [TAG_W-1:0]  tag_tbl [REG_NUM],
  input  commit_t           cmt,
  output operand_t          opnd
);

  // Table lookup, with the commit bypass taking priority over a stale busy entry.
  always_comb begin
    opnd = '0;
    if (rs != '0) begin
      opnd.value = value_tbl[rs];
      opnd.tag   = tag_tbl[rs];
      opnd.busy  = busy_tbl[rs];
      if (cmt.valid && (cmt.rd == rs) && busy_tbl[rs] && (tag_tbl[rs] == cmt.tag)) begin
        opnd.busy  = 1'b0;
        opnd.value = cmt.data;
      end
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename status.
// For each accepted instruction, the two sources are resolved to a ready
// value or a pending ROB tag, and the destination is renamed to the new tag.
// Results are presented one cycle later through a valid/ready holding register.
// Held operands still wake up on commits while downstream stalls.
module rename_reg_file
  import rf_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int AW      = $clog2(REG_NUM)
) (
  input logic              clk,
  input logic              rst,
  rename_reg_file_if.slave bus
);

  // Rename table state. Entry 0 is never written, so x0 stays zero and idle.
  logic [DATA_W-1:0]  value_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [TAG_W-1:0]   tag_q   [REG_NUM];

  // Output holding register.
  logic              out_valid_q;
  operand_t          held1_q;
  operand_t          held2_q;
  logic [TAG_W-1:0]  out_tag_q;

  logic              issue_ready;
  logic              accept;
  commit_t           cmt;
  operand_t          opnd1;
  operand_t          opnd2;

  // A flush blocks the accept.
  // Otherwise, accept whenever the holding register is empty or is being drained.
  assign issue_ready = !bus.flush_i && (!out_valid_q || bus.out_ready_i);
  assign accept      = bus.issue_valid_i && issue_ready;

  // Bundle the commit port so the resolvers and the wake-up logic share one view.
  always_comb begin
    cmt       = '0;
    cmt.valid = bus.commit_valid_i;
    cmt.rd    = bus.commit_rd_i;
    cmt.tag   = bus.commit_tag_i;
    cmt.data  = bus.commit_data_i;
  end

  rf_operand_resolve #(
    .REG_NUM (REG_NUM),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .AW      (AW)
  ) u_resolve_rs1 (
    .rs        (bus.issue_rs1_i),
    .value_tbl (value_q),
    .busy_tbl  (busy_q),
    .tag_tbl   (tag_q),
    .cmt       (cmt),
    .opnd      (opnd1)
  );

  rf_operand_resolve #(
    .REG_NUM (REG_NUM),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .AW      (AW)
  ) u_resolve_rs2 (
    .rs        (bus.issue_rs2_i),
    .value_tbl (value_q),
    .busy_tbl  (busy_q),
    .tag_tbl   (tag_q),
    .cmt       (cmt),
    .opnd      (opnd2)
  );

  // Table update:
  // - a commit always writes the value, even during a flush;
  // - a flush clears every busy bit;
  // - a rename of the same register wins over the commit's busy clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (cmt.valid && (cmt.rd == AW'(i))) begin
          value_q[i] <= cmt.data;
        end
        if (bus.flush_i) begin
          busy_q[i] <= 1'b0;
        end else if (accept && (bus.issue_rd_i == AW'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= bus.issue_tag_i;
        end else if (cmt.valid && (cmt.rd == AW'(i)) && (tag_q[i] == cmt.tag)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Holding register update:
  // - load on accept;
  // - drop on handshake or flush;
  // - while stalled, keep the payload and wake pending operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      held1_q     <= '0;
      held2_q     <= '0;
      out_tag_q   <= '0;
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      held1_q     <= opnd1;
      held2_q     <= opnd2;
      out_tag_q   <= bus.issue_tag_i;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      held1_q <= wake_operand(held1_q, cmt);
      held2_q <= wake_operand(held2_q, cmt);
    end
  end

  assign bus.issue_ready_o = issue_ready;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_v1_o      = held1_q.value;
  assign bus.out_v2_o      = held2_q.value;
  assign bus.out_q1_o      = held1_q.tag;
  assign bus.out_q2_o      = held2_q.tag;
  assign bus.out_busy1_o   = held1_q.busy;
  assign bus.out_busy2_o   = held2_q.busy;
  assign bus.out_tag_o     = out_tag_q;

endmodule
